// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared definitions for the ULPI register sequencer.
//   state_t   - sequencer state encoding
//   ADDR_*    - commonly used ULPI register addresses
package ulpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
  localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] ADDR_SCRATCH   = 6'h16;

endpackage

// File: rtl/ulpi_reg_seq.sv
// ulpi_reg_seq: one-at-a-time register access sequencer in front of the ULPI
// wrapper register port. Issues a one-cycle REG_EN strobe, waits for
// REG_DONE / REG_FAIL with a timeout, retries with a backoff gap, and returns
// exactly one response per accepted request.
//
// Ports
//   CLK_60M, RST_A_USB        clock / async active-high reset
//   ULPI_READY                link-up; low aborts an in-flight request
//   REQ_VALID/READY/RW/ADDR/DATA   request handshake
//   RSP_VALID/READY/OK/ABORT/DATA/TRIES  response handshake
//   REG_EN/RW/ADDR/DATA_I     access strobe and registered request fields
//   REG_DATA_O/DONE/FAIL      wrapper read data and completion status
//   BUSY                      sequencer not idle
module ulpi_reg_seq #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int BACKOFF_CYC = 4
) (
  input  logic       CLK_60M,
  input  logic       RST_A_USB,
  input  logic       ULPI_READY,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RW,
  input  logic [5:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic       RSP_OK,
  output logic       RSP_ABORT,
  output logic [7:0] RSP_DATA,
  output logic [2:0] RSP_TRIES,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  input  logic [7:0] REG_DATA_O,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  output logic       BUSY
);
  import ulpi_pkg::*;

  localparam logic [2:0]  MAX_TRY = 3'(MAX_RETRY);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  BO_LAST = 8'(BACKOFF_CYC - 1);

  state_t      state;
  logic [2:0]  try_cnt;
  logic [15:0] to_cnt;
  logic [7:0]  bo_cnt;

  // Held low during reset so every output reads 0 while RST_A_USB is high.
  assign REQ_READY = (state == ST_IDLE) && ULPI_READY && !RST_A_USB;
  assign BUSY      = (state != ST_IDLE);

  always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
    if (RST_A_USB) begin
      state      <= ST_IDLE;
      try_cnt    <= '0;
      to_cnt     <= '0;
      bo_cnt     <= '0;
      REG_EN     <= 1'b0;
      REG_RW     <= 1'b0;
      REG_ADDR   <= '0;
      REG_DATA_I <= '0;
      RSP_VALID  <= 1'b0;
      RSP_OK     <= 1'b0;
      RSP_ABORT  <= 1'b0;
      RSP_DATA   <= '0;
      RSP_TRIES  <= '0;
    end else begin
      // REG_EN is registered: it is raised on the edge entering ISSUE so the
      // strobe covers exactly the ISSUE cycle.
      REG_EN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            REG_RW     <= REQ_RW;
            REG_ADDR   <= REQ_ADDR;
            REG_DATA_I <= REQ_DATA;
            try_cnt    <= '0;
            REG_EN     <= 1'b1;
            state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!ULPI_READY) begin
            RSP_VALID <= 1'b1;
            RSP_OK    <= 1'b0;
            RSP_ABORT <= 1'b1;
            RSP_DATA  <= '0;
            RSP_TRIES <= try_cnt;
            state     <= ST_RESP;
          end else begin
            to_cnt <= '0;
            state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!ULPI_READY) begin
            RSP_VALID <= 1'b1;
            RSP_OK    <= 1'b0;
            RSP_ABORT <= 1'b1;
            RSP_DATA  <= '0;
            RSP_TRIES <= try_cnt;
            state     <= ST_RESP;
          end else if (REG_DONE) begin
            RSP_VALID <= 1'b1;
            RSP_OK    <= 1'b1;
            RSP_ABORT <= 1'b0;
            RSP_DATA  <= REG_RW ? REG_DATA_I : REG_DATA_O;
            RSP_TRIES <= try_cnt;
            state     <= ST_RESP;
          end else if (REG_FAIL || (to_cnt == TO_LAST)) begin
            if (try_cnt < MAX_TRY) begin
              try_cnt <= try_cnt + 3'd1;
              if (BACKOFF_CYC == 0) begin
                // No gap requested: reissue on the very next cycle.
                REG_EN <= 1'b1;
                state  <= ST_ISSUE;
              end else begin
                bo_cnt <= '0;
                state  <= ST_BACKOFF;
              end
            end else begin
              RSP_VALID <= 1'b1;
              RSP_OK    <= 1'b0;
              RSP_ABORT <= 1'b0;
              RSP_DATA  <= '0;
              RSP_TRIES <= try_cnt;
              state     <= ST_RESP;
            end
          end else if (to_cnt != 16'hFFFF) begin
            to_cnt <= to_cnt + 16'd1;
          end
        end

        ST_BACKOFF: begin
          if (!ULPI_READY) begin
            // Aborting here also keeps the pending reissue strobe from firing.
            RSP_VALID <= 1'b1;
            RSP_OK    <= 1'b0;
            RSP_ABORT <= 1'b1;
            RSP_DATA  <= '0;
            RSP_TRIES <= try_cnt;
            state     <= ST_RESP;
          end else if (bo_cnt == BO_LAST) begin
            REG_EN <= 1'b1;
            state  <= ST_ISSUE;
          end else if (bo_cnt != 8'hFF) begin
            bo_cnt <= bo_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_seq.sv
// tb_ulpi_reg_seq: directed + randomized checks of ulpi_reg_seq against a
// timing/outcome model derived from the access rules (attempt outcomes,
// wait lengths, backoff gap).
module tb_ulpi_reg_seq;

  localparam int MAX_RETRY   = 3;
  localparam int TIMEOUT_CYC = 8;
  localparam int BACKOFF_CYC = 4;

  localparam int K_DONE = 0;
  localparam int K_FAIL = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;

  logic       CLK_60M = 1'b0;
  logic       RST_A_USB, ULPI_READY, REQ_VALID, REQ_READY, REQ_RW;
  logic [5:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID, RSP_READY, RSP_OK, RSP_ABORT;
  logic [7:0] RSP_DATA;
  logic [2:0] RSP_TRIES;
  logic       REG_EN, REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I, REG_DATA_O;
  logic       REG_DONE, REG_FAIL, BUSY;

  int errors = 0;
  int checks = 0;
  int kind[4];
  int dly[4];

  always #5 CLK_60M = ~CLK_60M;

  ulpi_reg_seq #(
    .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC), .BACKOFF_CYC(BACKOFF_CYC)
  ) dut (
    .CLK_60M(CLK_60M), .RST_A_USB(RST_A_USB), .ULPI_READY(ULPI_READY),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RW(REQ_RW),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_OK(RSP_OK),
    .RSP_ABORT(RSP_ABORT), .RSP_DATA(RSP_DATA), .RSP_TRIES(RSP_TRIES),
    .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR),
    .REG_DATA_I(REG_DATA_I), .REG_DATA_O(REG_DATA_O),
    .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request: kind[]/dly[] script the wrapper's reaction per attempt
  // (dly = WAIT cycle, counted from 1, in which DONE/FAIL is raised).
  task automatic run_req(input logic rw, input logic [5:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int hold);
    int exp_tries, lat, att, since, cyc, w;
    int t_exp[4];
    bit ok_e;
    // model: first successful attempt decides outcome; times are cumulative
    exp_tries = MAX_RETRY;
    ok_e = 1'b0;
    for (int k = 0; k <= MAX_RETRY; k++)
      if (!ok_e && (kind[k] == K_DONE || kind[k] == K_BOTH)) begin
        exp_tries = k;
        ok_e = 1'b1;
      end
    t_exp[0] = 1;
    lat = 0;
    for (int k = 0; k <= exp_tries; k++) begin
      w = (kind[k] == K_NONE) ? TIMEOUT_CYC : dly[k];
      if (k < exp_tries) t_exp[k+1] = t_exp[k] + 1 + w + BACKOFF_CYC;
      else lat = t_exp[k] + w + 1;
    end

    REQ_VALID = 1'b1; REQ_RW = rw; REQ_ADDR = addr; REQ_DATA = wd; REG_DATA_O = rd;
    chk("req_ready_idle", {31'd0, REQ_READY}, 32'd1);
    @(negedge CLK_60M);
    REQ_VALID = 1'b0;
    REQ_DATA = ~wd; // request fields must already be latched
    cyc = 1; att = 0; since = -1;
    while (!RSP_VALID && cyc < 2000) begin
      if (REG_EN) begin
        if (att < 4) chk("reg_en_time", cyc, t_exp[att]);
        chk("reg_addr", {26'd0, REG_ADDR}, {26'd0, addr});
        chk("reg_data_i", {24'd0, REG_DATA_I}, {24'd0, wd});
        chk("reg_rw", {31'd0, REG_RW}, {31'd0, rw});
        att++;
        since = 0;
      end else if (since >= 0) since++;
      REG_DONE = 1'b0; REG_FAIL = 1'b0;
      if (att > 0 && att <= 4 && since > 0 && since == dly[att-1]) begin
        REG_DONE = (kind[att-1] == K_DONE || kind[att-1] == K_BOTH);
        REG_FAIL = (kind[att-1] == K_FAIL || kind[att-1] == K_BOTH);
      end
      @(negedge CLK_60M);
      cyc++;
    end
    REG_DONE = 1'b0; REG_FAIL = 1'b0;
    chk("rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("rsp_latency", cyc, lat);
    chk("reg_en_count", att, exp_tries + 1);
    chk("rsp_ok", {31'd0, RSP_OK}, {31'd0, ok_e});
    chk("rsp_abort", {31'd0, RSP_ABORT}, 32'd0);
    chk("rsp_tries", {29'd0, RSP_TRIES}, exp_tries);
    if (ok_e) chk("rsp_data", {24'd0, RSP_DATA}, {24'd0, rw ? wd : rd});

    // hold the response; a stray DONE/FAIL and a pending request must not disturb it
    REQ_VALID = 1'b1;
    for (int h = 0; h < hold; h++) begin
      REG_DONE = (h == 0); REG_FAIL = (h == 1);
      @(negedge CLK_60M);
      chk("rsp_hold_valid", {31'd0, RSP_VALID}, 32'd1);
      chk("rsp_hold_noreq", {31'd0, REQ_READY}, 32'd0);
      chk("rsp_hold_ok", {31'd0, RSP_OK}, {31'd0, ok_e});
      chk("rsp_hold_tries", {29'd0, RSP_TRIES}, exp_tries);
    end
    REG_DONE = 1'b0; REG_FAIL = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLK_60M);
    RSP_READY = 1'b0;
    REQ_VALID = 1'b0;
    chk("rsp_drop", {31'd0, RSP_VALID}, 32'd0);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    chk("idle_req_ready", {31'd0, REQ_READY}, 32'd1);
  endtask

  task automatic set_plan(input int k0, input int k1, input int k2, input int k3, input int d);
    kind[0] = k0; kind[1] = k1; kind[2] = k2; kind[3] = k3;
    for (int i = 0; i < 4; i++) dly[i] = d;
  endtask

  initial begin
    int seen;
    RST_A_USB = 1'b1; ULPI_READY = 1'b1; REQ_VALID = 1'b0; REQ_RW = 1'b0;
    REQ_ADDR = '0; REQ_DATA = '0; RSP_READY = 1'b0; REG_DATA_O = '0;
    REG_DONE = 1'b0; REG_FAIL = 1'b0;
    #1;
    chk("rst_reg_en", {31'd0, REG_EN}, 32'd0);
    chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_req_ready", {31'd0, REQ_READY}, 32'd0);
    chk("rst_fields", {15'd0, REG_ADDR, REG_DATA_I, RSP_DATA, RSP_TRIES}, 32'd0);
    repeat (3) @(negedge CLK_60M);
    RST_A_USB = 1'b0;
    @(negedge CLK_60M);

    // write SCRATCH, immediate DONE
    set_plan(K_DONE, K_DONE, K_DONE, K_DONE, 1);
    run_req(1'b1, 6'h16, 8'hA5, 8'h00, 0);
    // read SCRATCH, response held 5 cycles
    set_plan(K_DONE, K_DONE, K_DONE, K_DONE, 1);
    run_req(1'b0, 6'h16, 8'h00, 8'h3C, 5);
    // two failures then success
    set_plan(K_FAIL, K_FAIL, K_DONE, K_DONE, 1);
    run_req(1'b1, 6'h04, 8'h5A, 8'h11, 1);
    // all attempts time out
    set_plan(K_NONE, K_NONE, K_NONE, K_NONE, 1);
    run_req(1'b0, 6'h0A, 8'h00, 8'h77, 0);
    // DONE and FAIL together: DONE wins
    set_plan(K_BOTH, K_FAIL, K_FAIL, K_FAIL, 2);
    run_req(1'b0, 6'h0A, 8'h00, 8'hC3, 0);

    // randomized requests
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        kind[i] = int'($urandom_range(0, 3));
        dly[i]  = int'($urandom_range(1, TIMEOUT_CYC));
      end
      run_req(1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    // link drop during WAIT -> abort response
    REQ_VALID = 1'b1; REQ_RW = 1'b0; REQ_ADDR = 6'h16;
    @(negedge CLK_60M);
    REQ_VALID = 1'b0;
    chk("abort_issue_en", {31'd0, REG_EN}, 32'd1);
    @(negedge CLK_60M);
    ULPI_READY = 1'b0;
    @(negedge CLK_60M);
    chk("abort_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("abort_rsp_ok", {31'd0, RSP_OK}, 32'd0);
    chk("abort_rsp_abort", {31'd0, RSP_ABORT}, 32'd1);
    RSP_READY = 1'b1;
    @(negedge CLK_60M);
    RSP_READY = 1'b0;
    REQ_VALID = 1'b1;
    chk("abort_idle", {31'd0, BUSY}, 32'd0);
    chk("abort_no_req_ready", {31'd0, REQ_READY}, 32'd0);
    @(negedge CLK_60M);
    chk("link_down_no_accept", {31'd0, BUSY}, 32'd0);
    REQ_VALID = 1'b0;
    ULPI_READY = 1'b1;
    #1;
    chk("link_up_req_ready", {31'd0, REQ_READY}, 32'd1);
    @(negedge CLK_60M);

    // async reset during WAIT
    REQ_VALID = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 6'h04; REQ_DATA = 8'hFF;
    @(negedge CLK_60M);
    REQ_VALID = 1'b0;
    @(negedge CLK_60M);
    chk("rst_mid_busy_before", {31'd0, BUSY}, 32'd1);
    RST_A_USB = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {REG_EN, REG_RW, RSP_VALID, RSP_OK, RSP_ABORT, BUSY, REQ_READY, REG_ADDR, REG_DATA_I, RSP_DATA},
        32'd0);
    @(negedge CLK_60M);
    RST_A_USB = 1'b0;
    seen = 0;
    repeat (20) begin
      REG_DONE = 1'b1;
      @(negedge CLK_60M);
      if (RSP_VALID || REG_EN) seen++;
    end
    REG_DONE = 1'b0;
    chk("rst_mid_no_rsp", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
